// File: rtl/video_fpga_top.sv
// Raster timing + grid test pattern (COLOR_BARS_EN selects colour bars), status LEDs, aux-clock select.
// Latency: VGA outputs registered 1 clk after (h,v); free-running, no backpressure.
module video_fpga_top #(
    parameter int HDISP     = 800,
    parameter int VDISP     = 480,
    parameter int HFP       = 40,
    parameter int HPULSE    = 48,
    parameter int HBP       = 40,
    parameter int VFP       = 13,
    parameter int VPULSE    = 3,
    parameter int VBP       = 29,
    parameter int BLINK_DIV = 25000000
) (
    input  logic       fpga_CLK,
    input  logic       fpga_RST,
    input  logic       fpga_SW0,
    input  logic       fpga_SW1,
    output logic       fpga_LEDR0,
    output logic       fpga_LEDR1,
    output logic       fpga_LEDR2,
    output logic       fpga_LEDR3,
    output logic       fpga_SEL_CLK_AUX,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK,
    output logic       VGA_SYNC,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B
);

    localparam int HTOT = HDISP + HFP + HPULSE + HBP;
    localparam int VTOT = VDISP + VFP + VPULSE + VBP;
    localparam int HW   = $clog2(HTOT);
    localparam int VW   = $clog2(VTOT);
    localparam int DW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [HW-1:0] H_LAST   = HW'(HTOT - 1);
    localparam logic [HW-1:0] H_VIS    = HW'(HDISP);
    localparam logic [HW-1:0] H_SYNC_S = HW'(HDISP + HFP);
    localparam logic [HW-1:0] H_SYNC_E = HW'(HDISP + HFP + HPULSE);
    localparam logic [VW-1:0] V_LAST   = VW'(VTOT - 1);
    localparam logic [VW-1:0] V_VIS    = VW'(VDISP);
    localparam logic [VW-1:0] V_SYNC_S = VW'(VDISP + VFP);
    localparam logic [VW-1:0] V_SYNC_E = VW'(VDISP + VFP + VPULSE);
    localparam logic [DW-1:0] DIV_LAST = DW'(BLINK_DIV - 1);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [DW-1:0] div_q, div_d;
    logic          hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
    logic [23:0]   rgb_q, rgb_d;
    logic          led0_q, led0_d, led2_q, led2_d, led3_q, led3_d;
    logic [1:0]    sw0_q, sw0_d, sw1_q, sw1_d;
    logic          visible;
`ifdef COLOR_BARS_EN
    logic [HW+2:0] h8;
    logic [2:0]    bar;
`endif

    always_comb begin
        h_d    = h_q + HW'(1);
        v_d    = v_q;
        led3_d = led3_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            if (v_q == V_LAST) begin
                v_d    = '0;
                led3_d = ~led3_q;
            end else begin
                v_d = v_q + VW'(1);
            end
        end

        visible = (h_q < H_VIS) && (v_q < V_VIS);
        hs_d    = !((h_q >= H_SYNC_S) && (h_q < H_SYNC_E));
        vs_d    = !((v_q >= V_SYNC_S) && (v_q < V_SYNC_E));
        blank_d = visible;
        rgb_d   = '0;
`ifdef COLOR_BARS_EN
        // bar index = floor(h*8/HDISP), found by threshold compare instead of a divider
        h8  = {h_q, 3'b000};
        bar = '0;
        for (int k = 1; k < 8; k++) begin
            if (h8 >= (HW+3)'(k * HDISP)) bar = 3'(k);
        end
        if (visible) rgb_d = {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
`else
        if (visible && ((h_q[3:0] == 4'd0) || (v_q[3:0] == 4'd0))) rgb_d = '1;
`endif

        div_d  = div_q + DW'(1);
        led0_d = led0_q;
        if (div_q == DIV_LAST) begin
            div_d  = '0;
            led0_d = ~led0_q;
        end
        led2_d = 1'b1;
        sw0_d  = {sw0_q[0], fpga_SW0};
        sw1_d  = {sw1_q[0], fpga_SW1};
    end

    always_ff @(posedge fpga_CLK or posedge fpga_RST) begin
        if (fpga_RST) begin
            h_q     <= '0;
            v_q     <= '0;
            div_q   <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
            rgb_q   <= '0;
            led0_q  <= 1'b0;
            led2_q  <= 1'b0;
            led3_q  <= 1'b0;
            sw0_q   <= '0;
            sw1_q   <= '0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            div_q   <= div_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
            rgb_q   <= rgb_d;
            led0_q  <= led0_d;
            led2_q  <= led2_d;
            led3_q  <= led3_d;
            sw0_q   <= sw0_d;
            sw1_q   <= sw1_d;
        end
    end

    assign fpga_LEDR0       = led0_q;
    assign fpga_LEDR1       = sw0_q[1];
    assign fpga_LEDR2       = led2_q;
    assign fpga_LEDR3       = led3_q;
    assign fpga_SEL_CLK_AUX = sw1_q[1];
    assign VGA_CLK          = ~fpga_CLK;
    assign VGA_HS           = hs_q;
    assign VGA_VS           = vs_q;
    assign VGA_BLANK        = blank_q;
    assign VGA_SYNC         = 1'b0;
    assign VGA_R            = rgb_q[23:16];
    assign VGA_G            = rgb_q[15:8];
    assign VGA_B            = rgb_q[7:0];

endmodule

// File: tb/tb_video_fpga_top.sv
// Scoreboard bench for video_fpga_top at 160x90, BLINK_DIV=10; expected values are hand-derived per pixel/cycle.
module tb_video_fpga_top;

    localparam int HT = 288;
    localparam int FR = 288 * 135;
    localparam int F_HS = 0, F_VS = 1, F_BLANK = 2, F_RGB = 3, F_L0 = 4, F_L1 = 5,
                   F_L2 = 6, F_L3 = 7, F_SEL = 8, F_SYNC = 9, F_VCLK = 10;
`ifdef COLOR_BARS_EN
    localparam bit BARS = 1'b1;
`else
    localparam bit BARS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sw0 = 1'b0;
    logic       sw1 = 1'b0;
    logic       led0, led1, led2, led3, sel_aux, vga_clk, hs, vs, blank, vsync;
    logic [7:0] r, g, b;
    int         cyc = 0;

    video_fpga_top #(.HDISP(160), .VDISP(90), .BLINK_DIV(10)) dut (
        .fpga_CLK(clk), .fpga_RST(rst), .fpga_SW0(sw0), .fpga_SW1(sw1),
        .fpga_LEDR0(led0), .fpga_LEDR1(led1), .fpga_LEDR2(led2), .fpga_LEDR3(led3),
        .fpga_SEL_CLK_AUX(sel_aux), .VGA_CLK(vga_clk), .VGA_HS(hs), .VGA_VS(vs),
        .VGA_BLANK(blank), .VGA_SYNC(vsync), .VGA_R(r), .VGA_G(g), .VGA_B(b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        int          t;
        int          fld;
        logic [23:0] exp;
    } chk_t;

    chk_t sb[$];
    int   last_t = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   done = 1'b0;
    bit   reported = 1'b0;

    function automatic logic [23:0] obs(input int f);
        case (f)
            F_HS:    return {23'd0, hs};
            F_VS:    return {23'd0, vs};
            F_BLANK: return {23'd0, blank};
            F_RGB:   return {r, g, b};
            F_L0:    return {23'd0, led0};
            F_L1:    return {23'd0, led1};
            F_L2:    return {23'd0, led2};
            F_L3:    return {23'd0, led3};
            F_SEL:   return {23'd0, sel_aux};
            F_SYNC:  return {23'd0, vsync};
            default: return {23'd0, vga_clk};
        endcase
    endfunction

    function automatic logic [23:0] pick(input logic [23:0] grid, input logic [23:0] bars);
        return BARS ? bars : grid;
    endfunction

    task automatic push(input string name, input int t, input int fld, input logic [23:0] exp);
        chk_t c;
        c.name = name;
        c.t    = t;
        c.fld  = fld;
        c.exp  = exp;
        sb.push_back(c);
        if (t > last_t) last_t = t;
    endtask

    // pixel (h,v) of frame f after release at cycle base is presented at cycle base+1+index
    task automatic pix(input string name, input int base, input int h, input int v, input int f,
                       input int fld, input logic [23:0] exp);
        push(name, base + 1 + f * FR + v * HT + h, fld, exp);
    endtask

    task automatic reset_vals(input string tag, input int t);
        push({tag, "_hs"}, t, F_HS, 24'h1);
        push({tag, "_vs"}, t, F_VS, 24'h1);
        push({tag, "_blank"}, t, F_BLANK, 24'h0);
        push({tag, "_rgb"}, t, F_RGB, 24'h0);
        push({tag, "_led0"}, t, F_L0, 24'h0);
        push({tag, "_led1"}, t, F_L1, 24'h0);
        push({tag, "_led2"}, t, F_L2, 24'h0);
        push({tag, "_led3"}, t, F_L3, 24'h0);
        push({tag, "_sel"}, t, F_SEL, 24'h0);
        push({tag, "_sync"}, t, F_SYNC, 24'h0);
    endtask

    // monitor: samples just after the falling edge, well away from the active edge
    always @(negedge clk) begin
        #1;
        for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
            if (sb[i].t == cyc) begin
                n_chk++;
                if (obs(sb[i].fld) !== sb[i].exp) begin
                    n_fail++;
                    $display("FAIL %s at cycle %0d: got %h, expected %h",
                             sb[i].name, cyc, obs(sb[i].fld), sb[i].exp);
                end
                sb.delete(i);
            end
        end
        if (done && !reported) begin
            reported = 1'b1;
            foreach (sb[i]) begin
                n_fail++;
                $display("FAIL %s never sampled (due cycle %0d)", sb[i].name, sb[i].t);
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, base2, c_rst;
        sw0 = 1'b1;
        sw1 = 1'b1;
        reset_vals("rst_a", 10);
        reset_vals("rst_b", 25);

        while (cyc != 30) @(negedge clk);
        rst  = 1'b0;
        base = 30;

        push("led2_alive", base + 1, F_L2, 24'h1);
        push("led1_pre", base + 1, F_L1, 24'h0);
        push("led1_sync", base + 2, F_L1, 24'h1);
        push("sel_pre", base + 1, F_SEL, 24'h0);
        push("sel_sync", base + 2, F_SEL, 24'h1);
        push("led0_9", base + 9, F_L0, 24'h0);
        push("led0_10", base + 10, F_L0, 24'h1);
        push("led0_19", base + 19, F_L0, 24'h1);
        push("led0_20", base + 20, F_L0, 24'h0);

        pix("rgb_0_0", base, 0, 0, 0, F_RGB, pick(24'hFFFFFF, 24'h000000));
        pix("blank_0_0", base, 0, 0, 0, F_BLANK, 24'h1);
        pix("hs_0_0", base, 0, 0, 0, F_HS, 24'h1);
        pix("vs_0_0", base, 0, 0, 0, F_VS, 24'h1);
        pix("sync_0_0", base, 0, 0, 0, F_SYNC, 24'h0);
        pix("vgaclk", base, 0, 0, 0, F_VCLK, 24'h1);
        pix("rgb_1_1", base, 1, 1, 0, F_RGB, 24'h000000);
        pix("rgb_16_5", base, 16, 5, 0, F_RGB, pick(24'hFFFFFF, 24'h000000));
        pix("rgb_159_5", base, 159, 5, 0, F_RGB, pick(24'h000000, 24'hFFFFFF));
        pix("blank_159_5", base, 159, 5, 0, F_BLANK, 24'h1);
        pix("rgb_20_3", base, 20, 3, 0, F_RGB, pick(24'h000000, 24'h0000FF));
        pix("blank_160_5", base, 160, 5, 0, F_BLANK, 24'h0);
        pix("rgb_160_5", base, 160, 5, 0, F_RGB, 24'h0);
        pix("blank_287_5", base, 287, 5, 0, F_BLANK, 24'h0);
        pix("blank_0_6", base, 0, 6, 0, F_BLANK, 24'h1);
        pix("rgb_80_16", base, 80, 16, 0, F_RGB, pick(24'hFFFFFF, 24'hFF0000));
        pix("rgb_100_89", base, 100, 89, 0, F_RGB, pick(24'h000000, 24'hFF00FF));
        pix("blank_0_89", base, 0, 89, 0, F_BLANK, 24'h1);
        pix("blank_0_90", base, 0, 90, 0, F_BLANK, 24'h0);
        pix("rgb_0_90", base, 0, 90, 0, F_RGB, 24'h0);
        pix("blank_0_134", base, 0, 134, 0, F_BLANK, 24'h0);
        for (int ln = 0; ln < 2; ln++) begin
            pix("hs_199", base, 199, ln, 0, F_HS, 24'h1);
            pix("hs_200", base, 200, ln, 0, F_HS, 24'h0);
            pix("hs_247", base, 247, ln, 0, F_HS, 24'h0);
            pix("hs_248", base, 248, ln, 0, F_HS, 24'h1);
        end
        pix("vs_287_102", base, 287, 102, 0, F_VS, 24'h1);
        pix("vs_0_103", base, 0, 103, 0, F_VS, 24'h0);
        pix("vs_287_105", base, 287, 105, 0, F_VS, 24'h0);
        pix("vs_0_106", base, 0, 106, 0, F_VS, 24'h1);
        pix("led3_before", base, 286, 134, 0, F_L3, 24'h0);
        pix("led3_after", base, 0, 0, 1, F_L3, 24'h1);
        pix("rgb_f1_16_0", base, 16, 0, 1, F_RGB, pick(24'hFFFFFF, 24'h000000));

        // mid-frame reset lands while pixel (16,40) of frame 1 is presented
        c_rst = base + 1 + FR + 40 * HT + 16;
        push("pre_blank", c_rst - 1, F_BLANK, 24'h1);
        push("pre_led2", c_rst - 1, F_L2, 24'h1);
        push("pre_led3", c_rst - 1, F_L3, 24'h1);
        push("pre_sel", c_rst - 1, F_SEL, 24'h1);
        reset_vals("async", c_rst);

        while (cyc != base + 50) @(negedge clk);
        sw0 = 1'b0;
        push("led1_hold", base + 51, F_L1, 24'h1);
        push("led1_fall", base + 52, F_L1, 24'h0);

        while (cyc != c_rst - 1) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;

        while (cyc != c_rst + 5) @(negedge clk);
        rst   = 1'b0;
        base2 = c_rst + 5;
        pix("re_blank_0_0", base2, 0, 0, 0, F_BLANK, 24'h1);
        pix("re_rgb_0_0", base2, 0, 0, 0, F_RGB, pick(24'hFFFFFF, 24'h000000));
        pix("re_led2", base2, 0, 0, 0, F_L2, 24'h1);
        pix("re_hs_199", base2, 199, 0, 0, F_HS, 24'h1);
        pix("re_hs_200", base2, 200, 0, 0, F_HS, 24'h0);
        pix("re_rgb_0_1", base2, 0, 1, 0, F_RGB, pick(24'hFFFFFF, 24'h000000));
        pix("re_rgb_20_1", base2, 20, 1, 0, F_RGB, pick(24'h000000, 24'h0000FF));

        while (cyc < last_t + 2) @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
